mio_mem_responder: RTL and testbench
====================================

// Module: mio_mem_responder
// PURPOSE
//  Memory-side responder for the SCPU external bus (CPU_MIO / mem_w / MIO_ready handshake).
//  Accepts word read/write requests, inserts WAIT_CYCLES wait states, performs the access on
//  an internal word RAM and returns a one-cycle MIO_ready completion pulse.
//  Sits between the SCPU data port and the data memory map; replaces the zero-wait DM model
//  so the pipeline's stall-on-!MIO_ready path is exercised.
// PARAMETERS
//  WAIT_CYCLES  2        wait states between request capture and completion (0..15)
//  ADDR_WIDTH   10       word-address bits; RAM depth = 2**ADDR_WIDTH words
//  BASE_ADDR    32'h0    byte base of decoded window; bits [ADDR_WIDTH+1:0] ignored
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high reset
//  CPU_MIO    in   1   request valid; CPU holds it and all request fields stable until MIO_ready
//  mem_w      in   1   1 = write, 0 = read
//  addr_in    in   32  byte address (from CPU Addr_out)
//  wr_data    in   32  write data (from CPU Data_out)
//  rd_data    out  32  read data (to CPU Data_in)
//  MIO_ready  out  1   completion pulse, exactly one cycle per accepted request
//  addr_err   out  1   high with MIO_ready when the completed request was rejected
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, dominates all edges): state=IDLE, cnt=0, MIO_ready=0, addr_err=0, rd_data=0.
//   RAM contents are not reset. Reset mid-transaction aborts: no write, no MIO_ready pulse.
//  FSM states: IDLE, WAIT, DONE.
//  IDLE: at an edge with CPU_MIO=1, capture addr_in/mem_w/wr_data.
//   If WAIT_CYCLES>0, go to WAIT with cnt=WAIT_CYCLES-1; else go to DONE.
//  WAIT: at each edge, if cnt==0 go to DONE, else decrement cnt. CPU_MIO is ignored.
//  Access happens at the edge that enters DONE, using the captured request.
//   For WAIT_CYCLES=0 this is the capture edge itself, so the live inputs are used.
//  Validity: ok = (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]) && (addr[1:0]==2'b00).
//  Word index: addr[ADDR_WIDTH+1:2].
//   ok & write:  RAM[idx] <= wr_data; rd_data unchanged.
//   ok & read:   rd_data <= RAM[idx].
//   !ok & write: no RAM update; rd_data unchanged.
//   !ok & read:  rd_data <= 0.
//   addr_err <= !ok.
//  DONE: MIO_ready=1 and addr_err valid for this single cycle.
//   Next edge: go to IDLE unconditionally; MIO_ready and addr_err return to 0.
//  rd_data is registered and holds until the next completed read (or reset).
//  Latency: request captured at edge k -> MIO_ready rises at edge k+WAIT_CYCLES, falls at edge
//   k+WAIT_CYCLES+1. The earliest next capture is edge k+WAIT_CYCLES+2.
//   Throughput is therefore one request per WAIT_CYCLES+2 cycles.
//  CPU_MIO dropping before MIO_ready is a protocol violation. The responder still completes
//   the captured request.
//  All outputs are driven from registers or from decoded state (no combinational input->output path).
// TESTING  (WAIT_CYCLES=2, ADDR_WIDTH=10, BASE_ADDR=0 unless stated)
//  1 Write 0x1234_5678 to 0x010, capture at edge k -> MIO_ready=1 only between edges k+2 and k+3;
//    addr_err=0; busy=1 from k to k+3.
//  2 Read 0x010 -> rd_data=0x1234_5678 with MIO_ready; value holds through 5 idle cycles.
//  3 Read 0x1000 (outside window) -> MIO_ready=1, addr_err=1, rd_data=0.
//    Then write 0xFFFF_FFFF to 0x1000; read 0x000 returns its prior value (no aliasing).
//  4 Read 0x012 (misaligned) -> addr_err=1. A following read of 0x010 has addr_err=0 and data intact.
//  5 Preload 0x020=0xAAAA_AAAA. Write 0x5555_5555 to 0x020 and assert reset during WAIT
//    -> outputs 0 immediately, no pulse. Read 0x020 after reset returns 0xAAAA_AAAA.
//  6 WAIT_CYCLES=0 instance, CPU_MIO held high for 6 cycles with changing addresses
//    -> MIO_ready on alternate cycles (3 pulses), each read returning its own address's data.

Source files
------------

// File: rtl/mio_mem_responder_if.sv
// Memory-side bus between the SCPU data port and mio_mem_responder.
// The CPU (master) raises CPU_MIO with a stable request and waits for the
// one-cycle MIO_ready completion returned by the responder (slave).
interface mio_mem_responder_if;

   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] addr_in;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        MIO_ready;
   logic        addr_err;
   logic        busy;

   modport master (
      output CPU_MIO,
      output mem_w,
      output addr_in,
      output wr_data,
      input  rd_data,
      input  MIO_ready,
      input  addr_err,
      input  busy
   );

   modport slave (
      input  CPU_MIO,
      input  mem_w,
      input  addr_in,
      input  wr_data,
      output rd_data,
      output MIO_ready,
      output addr_err,
      output busy
   );

endinterface : mio_mem_responder_if

// File: rtl/mio_mem_responder.sv
// Wait-state memory responder for the SCPU external bus.
// A request seen in IDLE is captured, held for WAIT_CYCLES wait states, then
// performed on an internal word RAM at the edge that enters DONE. DONE lasts
// one cycle and produces the MIO_ready pulse (plus addr_err for rejected
// requests). Requests outside the BASE_ADDR window or not word-aligned are
// rejected: writes are dropped, reads return zero.
module mio_mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic                 clk,
   input  logic                 reset,
   mio_mem_responder_if.slave   bus
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam int unsigned TAG_LSB   = ADDR_WIDTH + 2;
   localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
   // Wait-state counter reload; counts down to zero in WAIT.
   localparam logic [3:0]  CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;

   // Request captured at acceptance; used when the access is deferred.
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   // Request actually performed at the access edge.
   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_fire;
   logic        acc_ok;
   logic [ADDR_WIDTH-1:0] acc_idx;

   // Low while reset is asserted and for the first edge after its release,
   // so a request held high across reset can never reach the RAM.
   logic        out_of_reset;
   logic        accept;

   logic [31:0] mem [DEPTH];
   logic [31:0] rd_q;
   logic        err_q;

   assign accept = (state == ST_IDLE) && bus.CPU_MIO && out_of_reset;

   // Reset qualifier: set on every clock once reset has been released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) out_of_reset <= 1'b0;
      else       out_of_reset <= 1'b1;
   end

   // FSM state and wait counter register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of process ordering.
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // FSM next-state: IDLE accepts, WAIT counts down, DONE lasts one cycle.
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (ZERO_WAIT) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) state_nxt = ST_DONE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request capture register, loaded when a request is accepted in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_we    <= 1'b0;
         req_addr  <= 32'h0;
         req_wdata <= 32'h0;
      end else if (accept) begin
         req_we    <= bus.mem_w;
         req_addr  <= bus.addr_in;
         req_wdata <= bus.wr_data;
      end
   end

   // Access source and decode: live inputs for a zero-wait access, otherwise
   // the captured request at the end of the wait states.
   always_comb begin
      if (state == ST_IDLE) begin
         acc_we    = bus.mem_w;
         acc_addr  = bus.addr_in;
         acc_wdata = bus.wr_data;
      end else begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end
      acc_fire = (ZERO_WAIT && accept) ||
                 ((state == ST_WAIT) && (cnt == 4'd0));
      acc_ok   = (acc_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                 (acc_addr[1:0] == 2'b00);
      acc_idx  = acc_addr[TAG_LSB-1:2];
   end

   // Word RAM write port.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array has no reset; clearing it would prevent RAM
      // inference and its contents are defined only by writes.
      if (acc_fire && acc_ok && acc_we) mem[acc_idx] <= acc_wdata;
   end

   // Read data and error flag: rd_data holds until the next completed read,
   // addr_err is valid only for the DONE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q  <= 32'h0;
         err_q <= 1'b0;
      end else begin
         err_q <= acc_fire ? !acc_ok : 1'b0;
         if (acc_fire && !acc_we) rd_q <= acc_ok ? mem[acc_idx] : 32'h0;
      end
   end

   assign bus.rd_data   = rd_q;
   assign bus.addr_err  = err_q;
   assign bus.MIO_ready = (state == ST_DONE);
   assign bus.busy      = (state != ST_IDLE);

endmodule : mio_mem_responder

// File: tb/tb_mio_mem_responder.sv
// Directed bench for mio_mem_responder: a WAIT_CYCLES=2 instance for timing,
// window/alignment rejection and reset abort, and a WAIT_CYCLES=0 instance
// for back-to-back streaming.
module tb_mio_mem_responder;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   mio_mem_responder_if bus2 ();
   mio_mem_responder_if bus0 ();

   mio_mem_responder #(.WAIT_CYCLES(2), .ADDR_WIDTH(10), .BASE_ADDR(32'h0)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   mio_mem_responder #(.WAIT_CYCLES(0), .ADDR_WIDTH(10), .BASE_ADDR(32'h0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // sel=1 addresses the zero-wait instance, sel=0 the two-wait instance.
   task automatic drive(input bit sel, input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         bus0.CPU_MIO = v; bus0.mem_w = we; bus0.addr_in = a; bus0.wr_data = d;
      end else begin
         bus2.CPU_MIO = v; bus2.mem_w = we; bus2.addr_in = a; bus2.wr_data = d;
      end
   endtask

   task automatic sample(input bit sel, output logic rdy, output logic bsy,
                         output logic err, output logic [31:0] rd);
      if (sel) begin
         rdy = bus0.MIO_ready; bsy = bus0.busy; err = bus0.addr_err; rd = bus0.rd_data;
      end else begin
         rdy = bus2.MIO_ready; bsy = bus2.busy; err = bus2.addr_err; rd = bus2.rd_data;
      end
   endtask

   // One complete request: checks latency, busy, addr_err, rd_data and the
   // single-cycle pulse.
   task automatic do_req(input string tag, input bit sel, input logic we,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_rd);
      logic rdy, bsy, err;
      logic [31:0] rd;
      int n;
      int exp_lat;
      bit seen;
      exp_lat = sel ? 0 : 2;
      @(negedge clk);
      drive(sel, 1'b1, we, a, d);
      @(posedge clk);
      n = 0;
      seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         sample(sel, rdy, bsy, err, rd);
         if (n == 0) check({tag, " busy_start"}, 32'(bsy), 32'd1);
         if (rdy) seen = 1;
         else     n++;
      end
      check({tag, " ready_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, n, exp_lat);
      check({tag, " addr_err"}, 32'(err), 32'(exp_err));
      check({tag, " rd_data"}, rd, exp_rd);
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      sample(sel, rdy, bsy, err, rd);
      check({tag, " ready_fall"}, 32'(rdy), 32'd0);
      check({tag, " busy_end"}, 32'(bsy), 32'd0);
      check({tag, " err_fall"}, 32'(err), 32'd0);
   endtask

   logic [31:0] stream_addr [3];
   logic [31:0] stream_data [3];

   initial begin
      logic rdy, bsy, err;
      logic [31:0] rd;
      int k;
      int pulses;

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst rd_data",   bus2.rd_data,   32'h0);
      check("rst MIO_ready", 32'(bus2.MIO_ready), 32'd0);
      check("rst addr_err",  32'(bus2.addr_err),  32'd0);
      check("rst busy",      32'(bus2.busy),      32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: write with two wait states
      do_req("t1 wr010", 1'b0, 1'b1, 32'h010, 32'h1234_5678, 1'b0, 32'h0);

      // 2: read back and hold through idle cycles
      do_req("t2 rd010", 1'b0, 1'b0, 32'h010, 32'h0, 1'b0, 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2 hold", bus2.rd_data, 32'h1234_5678);
      end

      // 3: outside window, no aliasing onto word 0
      do_req("t3 wr000", 1'b0, 1'b1, 32'h000, 32'hCAFE_0001, 1'b0, 32'h1234_5678);
      do_req("t3 rd1000", 1'b0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
      do_req("t3 wr1000", 1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 1'b1, 32'h0);
      do_req("t3 rd000", 1'b0, 1'b0, 32'h000, 32'h0, 1'b0, 32'hCAFE_0001);

      // 4: misaligned accesses rejected, data intact
      do_req("t4 rd012", 1'b0, 1'b0, 32'h012, 32'h0, 1'b1, 32'h0);
      do_req("t4 rd010", 1'b0, 1'b0, 32'h010, 32'h0, 1'b0, 32'h1234_5678);
      do_req("t4 wr013", 1'b0, 1'b1, 32'h013, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
      do_req("t4 rd010b", 1'b0, 1'b0, 32'h010, 32'h0, 1'b0, 32'h1234_5678);

      // 5: reset during WAIT aborts the write
      do_req("t5 pre020", 1'b0, 1'b1, 32'h020, 32'hAAAA_AAAA, 1'b0, 32'h1234_5678);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h020, 32'h5555_5555);
      @(posedge clk);
      @(negedge clk);
      check("t5 in_wait busy", 32'(bus2.busy), 32'd1);
      reset = 1'b1;
      #1;
      check("t5 rst rd_data",   bus2.rd_data,        32'h0);
      check("t5 rst MIO_ready", 32'(bus2.MIO_ready), 32'd0);
      check("t5 rst addr_err",  32'(bus2.addr_err),  32'd0);
      check("t5 rst busy",      32'(bus2.busy),      32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5 no_pulse", 32'(bus2.MIO_ready), 32'd0);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      do_req("t5 rd020", 1'b0, 1'b0, 32'h020, 32'h0, 1'b0, 32'hAAAA_AAAA);

      // 6: zero-wait instance, CPU_MIO held high across three reads
      stream_addr[0] = 32'h040; stream_data[0] = 32'h0000_0040;
      stream_addr[1] = 32'h044; stream_data[1] = 32'h0000_0044;
      stream_addr[2] = 32'h048; stream_data[2] = 32'h0000_0048;
      do_req("t6 wr040", 1'b1, 1'b1, stream_addr[0], stream_data[0], 1'b0, 32'h0);
      do_req("t6 wr044", 1'b1, 1'b1, stream_addr[1], stream_data[1], 1'b0, 32'h0);
      do_req("t6 wr048", 1'b1, 1'b1, stream_addr[2], stream_data[2], 1'b0, 32'h0);
      @(negedge clk);
      k = 0;
      pulses = 0;
      drive(1'b1, 1'b1, 1'b0, stream_addr[0], 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sample(1'b1, rdy, bsy, err, rd);
         check("t6 ready_pattern", 32'(rdy), 32'((i % 2) == 0));
         if (rdy) begin
            pulses++;
            check("t6 rd_data", rd, stream_data[k]);
            check("t6 addr_err", 32'(err), 32'd0);
            if (k < 2) k++;
            drive(1'b1, 1'b1, 1'b0, stream_addr[k], 32'h0);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      check("t6 pulses", pulses, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "time limit reached");
   end

endmodule : tb_mio_mem_responder
